// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch/data) to one-slave memory bus arbiter with registered outputs, alternating priority on conflict.
// Optional slave timeout with bus error reporting is built in when MEM_ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_width,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_width,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

    if (TO_W < 31 && (1 << TO_W) <= TIMEOUT_CYCLES) begin : g_bad_to_w
        $error("TO_W too narrow for TIMEOUT_CYCLES");
    end

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [2:0]  m_width_q, m_width_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            i_err_q, i_err_d;
    logic            d_err_q, d_err_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_width_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt_q  <= '0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_width_q <= m_width_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            i_err_q   <= i_err_d;
            d_err_q   <= d_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_width_d = m_width_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        i_err_d   = 1'b0;
        d_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                // On conflict the master that did not win last time gets the bus.
                if (d_req && (!i_req || !last_d_q)) begin
                    state_d   = GNT_D;
                    last_d_d  = 1'b1;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_width_d = d_width;
                end else if (i_req) begin
                    state_d   = GNT_I;
                    last_d_d  = 1'b0;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                    m_width_d = 3'b010;
                end
            end
            GNT_I, GNT_D: begin
                if (m_ack) begin
                    m_req_d = 1'b0;
                    state_d = RESP;
                    if (state_q == GNT_D) begin
                        d_rdata_d = m_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = m_rdata;
                        i_ack_d   = 1'b1;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_LIMIT) begin
                    m_req_d = 1'b0;
                    state_d = RESP;
                    if (state_q == GNT_D) begin
                        d_rdata_d = '0;
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b1;
                    end else begin
                        i_rdata_d = '0;
                        i_ack_d   = 1'b1;
                        i_err_d   = 1'b1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_width = m_width_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign i_err   = i_err_q;
    assign d_err   = d_err_q;
`else
    assign i_err   = 1'b0;
    assign d_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: slave model checks bus transactions, monitor checks acks/data/timing.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_ack, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_ack, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [2:0]  d_width;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [2:0]  m_width;
    logic [31:0] m_rdata = 32'hBAD0_BAD0;
    logic        m_ack = 1'b0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_width(d_width),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_width(m_width),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  width;
        int          cyc;
    } bus_t;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          slave_waits = 0;
    int          wcnt = 0;
    int          c0;
    bus_t        exp_bus[$];
    resp_t       exp_resp[$];
    bus_t        eb;
    resp_t       er;
    logic [70:0] cur_bus;
    logic [31:0] exp_i_rd = '0;
    logic [31:0] exp_d_rd = '0;

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return {a[15:0], 16'hC0DE};
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Slave: acks after slave_waits wait cycles (negative = never), checks the request bus.
    always @(negedge clk) begin
        if (m_req) begin
            if (wcnt == 0) begin
                cur_bus = {m_we, m_addr, m_wdata, m_width};
                if (exp_bus.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bus_unexpected: got addr %0h expected no transaction", m_addr);
                end else begin
                    eb = exp_bus.pop_front();
                    chk("bus_cycle", 71'(cyc), 71'(eb.cyc));
                    chk("bus_we", 71'(m_we), 71'(eb.we));
                    chk("bus_addr", 71'(m_addr), 71'(eb.addr));
                    chk("bus_wdata", 71'(m_wdata), 71'(eb.wdata));
                    chk("bus_width", 71'(m_width), 71'(eb.width));
                end
            end else begin
                chk("bus_stable", {m_we, m_addr, m_wdata, m_width}, cur_bus);
            end
            if (slave_waits >= 0 && wcnt == slave_waits) begin
                m_ack   = 1'b1;
                m_rdata = m_we ? 32'h0 : slave_data(m_addr);
            end else begin
                m_ack   = 1'b0;
                m_rdata = 32'hBAD0_BAD0;
            end
            wcnt = wcnt + 1;
        end else begin
            m_ack   = 1'b0;
            m_rdata = 32'hBAD0_BAD0;
            wcnt    = 0;
        end
    end

    // Monitor: pops expected responses whenever an ack is presented.
    always @(negedge clk) begin
        if (rst) begin
            exp_i_rd = '0;
            exp_d_rd = '0;
        end
        if (i_ack || d_ack) begin
            chk("ack_exclusive", 71'(i_ack & d_ack), 71'(0));
            if (exp_resp.size() == 0) begin
                checks++; failures++;
                $display("FAIL ack_unexpected: got i_ack=%0b d_ack=%0b expected none", i_ack, d_ack);
            end else begin
                er = exp_resp.pop_front();
                chk("ack_master", 71'(d_ack), 71'(er.is_d));
                chk("ack_cycle", 71'(cyc), 71'(er.cyc));
                if (er.is_d) exp_d_rd = er.rdata;
                else         exp_i_rd = er.rdata;
                chk("i_rdata", 71'(i_rdata), 71'(exp_i_rd));
                chk("d_rdata", 71'(d_rdata), 71'(exp_d_rd));
                chk("ack_err", 71'(er.is_d ? d_err : i_err), 71'(er.err));
            end
        end else if (i_err || d_err) begin
            checks++; failures++;
            $display("FAIL err_without_ack: got i_err=%0b d_err=%0b expected 0", i_err, d_err);
        end
    end

    task automatic wait_ack(input bit is_d, input int limit);
        int n = 0;
        bit got = 0;
        while (!got && n < limit) begin
            @(negedge clk);
            got = is_d ? d_ack : i_ack;
            n++;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL ack_timeout: got no %s ack expected one within %0d cycles", is_d ? "d" : "i", limit);
        end
        @(posedge clk); #1;
    endtask

    task automatic push_bus(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] w, input int c);
        bus_t b;
        b.we = we; b.addr = a; b.wdata = wd; b.width = w; b.cyc = c;
        exp_bus.push_back(b);
    endtask

    task automatic push_resp(input logic is_d, input logic [31:0] rd, input logic err, input int c);
        resp_t r;
        r.is_d = is_d; r.rdata = rd; r.err = err; r.cyc = c;
        exp_resp.push_back(r);
    endtask

    task automatic do_reset;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation time limit expected normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_width = '0;
        repeat (2) @(posedge clk); #1;
        chk("rst_m_req", 71'(m_req), 71'(0));
        chk("rst_acks", 71'({i_ack, d_ack, i_err, d_err}), 71'(0));
        chk("rst_rdata", 71'({i_rdata, d_rdata}), 71'(0));
        chk("rst_bus", {m_we, m_addr, m_wdata, m_width}, 71'(0));
        rst = 1'b0;

        // Reset in the middle of a data grant that the slave never acks.
        slave_waits = -1;
        c0 = cyc;
        push_bus(1'b0, 32'h4000, 32'h0, 3'b000, c0 + 1);
        d_addr = 32'h4000; d_we = 0; d_width = 3'b000; d_req = 1;
        begin
            int n = 0;
            while (!m_req && n < 10) begin @(negedge clk); n++; end
            chk("mid_m_req_up", 71'(m_req), 71'(1));
        end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_async_m_req", 71'(m_req), 71'(0));
        chk("mid_rst_no_ack", 71'(d_ack), 71'(0));
        d_req = 0;
        repeat (2) @(posedge clk); #1 rst = 1'b0;

        // Store with three slave wait cycles.
        slave_waits = 3;
        c0 = cyc;
        push_bus(1'b1, 32'h2004, 32'hDEAD_BEEF, 3'b010, c0 + 1);
        push_resp(1'b1, 32'h0, 1'b0, c0 + 5);
        d_we = 1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_width = 3'b010; d_req = 1;
        wait_ack(1'b1, 20);
        d_req = 0; d_we = 0; d_wdata = '0;

        // Single fetch, zero-wait slave; master holds req through the ack cycle.
        slave_waits = 0;
        c0 = cyc;
        push_bus(1'b0, 32'h100, 32'h0, 3'b010, c0 + 1);
        push_resp(1'b0, 32'h0050_0093, 1'b0, c0 + 2);
        i_addr = 32'h100; i_req = 1;
        wait_ack(1'b0, 20);
        i_req = 0;
        repeat (4) begin
            @(negedge clk);
            chk("no_reissue", 71'(m_req), 71'(0));
        end
        @(posedge clk); #1;

        // Load with one wait cycle.
        slave_waits = 1;
        c0 = cyc;
        push_bus(1'b0, 32'h3000, 32'h0, 3'b100, c0 + 1);
        push_resp(1'b1, 32'h3000_C0DE, 1'b0, c0 + 3);
        d_addr = 32'h3000; d_width = 3'b100; d_req = 1;
        wait_ack(1'b1, 20);
        d_req = 0;

        // Continuous dual requests after reset: D, I, D, I every 3 cycles.
        do_reset;
        slave_waits = 0;
        c0 = cyc;
        i_addr = 32'h200; d_addr = 32'h3000; d_we = 0; d_width = 3'b100;
        push_bus(1'b0, 32'h3000, 32'h0, 3'b100, c0 + 1);
        push_bus(1'b0, 32'h200,  32'h0, 3'b010, c0 + 4);
        push_bus(1'b0, 32'h3000, 32'h0, 3'b100, c0 + 7);
        push_bus(1'b0, 32'h200,  32'h0, 3'b010, c0 + 10);
        push_resp(1'b1, 32'h3000_C0DE, 1'b0, c0 + 2);
        push_resp(1'b0, 32'h0200_C0DE, 1'b0, c0 + 5);
        push_resp(1'b1, 32'h3000_C0DE, 1'b0, c0 + 8);
        push_resp(1'b0, 32'h0200_C0DE, 1'b0, c0 + 11);
        i_req = 1; d_req = 1;
        wait_ack(1'b1, 10);
        wait_ack(1'b0, 10);
        wait_ack(1'b1, 10);
        wait_ack(1'b0, 10);
        i_req = 0; d_req = 0;

`ifdef MEM_ARB_TIMEOUT_EN
        // Slave never acks: timeout after four wait cycles with error and zeroed data.
        slave_waits = -1;
        c0 = cyc;
        push_bus(1'b0, 32'h5000, 32'h0, 3'b010, c0 + 1);
        push_resp(1'b1, 32'h0, 1'b1, c0 + 5);
        d_addr = 32'h5000; d_width = 3'b010; d_req = 1;
        wait_ack(1'b1, 20);
        d_req = 0;

        // Ack on the limit cycle wins over the timeout.
        slave_waits = 3;
        c0 = cyc;
        push_bus(1'b0, 32'h5000, 32'h0, 3'b010, c0 + 1);
        push_resp(1'b1, 32'h5000_C0DE, 1'b0, c0 + 5);
        d_req = 1;
        wait_ack(1'b1, 20);
        d_req = 0;
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("bus_queue_drained", 71'(exp_bus.size()), 71'(0));
        chk("resp_queue_drained", 71'(exp_resp.size()), 71'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
